lcd_frame_sched: RTL and testbench
==================================

LCD_FRAME_SCHED -- requirements
Module: lcd_frame_sched

Interface
REQ-001 SHALL have parameter H_RES, default 320, pixels per line (1..65535).
REQ-002 SHALL have parameter V_RES, default 240, lines per frame (1..65535).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port fmark_stb  input  1  one-cycle tearing-effect strobe from the PHY.
REQ-006 SHALL have port frame_req  input  1  GPU has a full frame ready; level signal.
REQ-007 SHALL have ports frame_busy output 1 (frame in progress) and frame_done output 1 (one-cycle end-of-frame pulse).
REQ-008 SHALL have ports pix_data input 16, pix_valid input 1, pix_ready output 1: RGB565 pixel stream.
REQ-009 SHALL have ports spi_data input 8, spi_rs input 1, spi_valid input 1, spi_ready output 1: SPI pass-through byte stream.
REQ-010 SHALL have ports phy_data output 8, phy_rs output 1, phy_valid output 1, phy_ready input 1: byte stream to the LCD PHY.

Function
REQ-011 SHALL implement FSM states IDLE, SPI, WAIT_SYNC, CMD, PIX; a byte transfers on a cycle with phy_valid & phy_ready.
REQ-012 In IDLE, SHALL go to SPI if spi_valid=1, else to WAIT_SYNC if frame_req=1; if both are asserted, SPI wins.
REQ-013 In SPI, SHALL forward spi_data/spi_rs/spi_valid to the PHY and drive spi_ready=phy_ready; SHALL return to IDLE on the first cycle spi_valid=0.
REQ-014 In WAIT_SYNC, SHALL drive phy_valid=0 and move to CMD on the cycle after fmark_stb=1; fmark_stb in any other state SHALL be ignored.
REQ-015 In CMD, SHALL emit 11 bytes in order: 0x2A(rs0), 0x00, 0x00, (H_RES-1)[15:8], (H_RES-1)[7:0], 0x2B(rs0), 0x00, 0x00, (V_RES-1)[15:8], (V_RES-1)[7:0], 0x2C(rs0); all bytes not marked rs0 use rs=1.
REQ-016 CMD SHALL hold each byte stable until it is accepted, and SHALL move to PIX after 0x2C is accepted.
REQ-017 In PIX, SHALL send each pixel as pix_data[15:8] then pix_data[7:0], both with rs=1.
REQ-018 In PIX, pix_ready SHALL be 1 only in the cycle the low byte is accepted; phy_valid SHALL equal pix_valid.
REQ-019 SHALL count pixels in a 32-bit counter and leave PIX after accepting the low byte of pixel H_RES*V_RES.
REQ-020 On leaving PIX, SHALL pulse frame_done for exactly that cycle and return to IDLE.
REQ-021 frame_busy SHALL be 1 in WAIT_SYNC, CMD and PIX, and 0 otherwise.
REQ-022 pix_ready SHALL be 0 outside PIX, and spi_ready SHALL be 0 outside SPI.
REQ-023 An SPI request arriving during a frame SHALL wait, with spi_ready=0, until the frame is done.
REQ-024 A pix_valid gap SHALL stall the transfer without losing byte order or count.
REQ-025 SHALL have no combinational path from phy_ready to phy_valid, phy_data or phy_rs.

Reset
REQ-026 While rst_n=0 at a clock edge, SHALL enter IDLE and clear the byte select and both counters.
REQ-027 While rst_n=0, SHALL drive phy_valid, pix_ready, spi_ready, frame_busy and frame_done to 0, and phy_data=0x00, phy_rs=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse; the next frame restarts at CMD byte 0.

Configuration
REQ-029 With LCD_SCHED_TEARSYNC_EN defined, the WAIT_SYNC behaviour of REQ-014 SHALL apply.
REQ-030 Without LCD_SCHED_TEARSYNC_EN, WAIT_SYNC SHALL pass to CMD unconditionally after one cycle, and fmark_stb SHALL be unused.

Structure
REQ-031 Package lcd_pkg SHALL hold the opcode constants (CASET 0x2A, PASET 0x2B, RAMWR 0x2C) and the FSM state enum.
REQ-032 Sub-module lcd_sched_cmdseq SHALL map a 4-bit index to {rs, data} for the CMD sequence, parameterised by H_RES and V_RES.

Verification (H_RES=4, V_RES=2, phy_ready=1 unless stated)
REQ-033 frame_req=1 then fmark_stb pulse -> PHY bytes 2A 00 00 00 03 2B 00 00 00 01 2C, then 16 pixel bytes, then one frame_done pulse.
REQ-034 spi_valid and frame_req raised in the same cycle, 3 SPI bytes -> the 3 SPI bytes go out first, then WAIT_SYNC.
REQ-035 Pixels 0x1234, 0xABCD with phy_ready toggling every cycle -> bytes 12 34 AB CD in order; pix_ready pulses exactly twice.
REQ-036 rst_n=0 for 1 cycle after 5 pixels -> all outputs 0 with no frame_done; the next frame begins with 0x2A.
REQ-037 Build without LCD_SCHED_TEARSYNC_EN, fmark_stb held 0 -> 0x2A appears within 3 cycles of frame_req.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants for the LCD frame scheduler: panel opcodes and FSM state encoding.
package lcd_pkg;

    localparam logic [7:0] CASET = 8'h2A;
    localparam logic [7:0] PASET = 8'h2B;
    localparam logic [7:0] RAMWR = 8'h2C;

    localparam logic [3:0] CMD_LAST = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPI,
        ST_WAIT_SYNC,
        ST_CMD,
        ST_PIX
    } sched_state_t;

endpackage

// File: rtl/lcd_sched_cmdseq.sv
// Window-setup command ROM: maps a byte index to {rs, data} for the
// CASET / PASET / RAMWR preamble that opens every frame.
module lcd_sched_cmdseq
    import lcd_pkg::*;
#(
    parameter int H_RES = 320,
    parameter int V_RES = 240
) (
    input  logic [3:0] idx,
    output logic       rs,
    output logic [7:0] data
);

    localparam logic [15:0] H_LAST = 16'(H_RES - 1);
    localparam logic [15:0] V_LAST = 16'(V_RES - 1);

    always_comb begin
        rs   = 1'b1;
        data = 8'h00;
        case (idx)
            4'd0: begin
                rs   = 1'b0;
                data = CASET;
            end
            4'd3: data = H_LAST[15:8];
            4'd4: data = H_LAST[7:0];
            4'd5: begin
                rs   = 1'b0;
                data = PASET;
            end
            4'd8: data = V_LAST[15:8];
            4'd9: data = V_LAST[7:0];
            4'd10: begin
                rs   = 1'b0;
                data = RAMWR;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lcd_frame_sched.sv
// LCD frame scheduler: arbitrates SPI pass-through and GPU frames onto one PHY byte stream.
// Tearing-effect synchronisation is enabled by defining LCD_SCHED_TEARSYNC_EN.
//
// state        | meaning
// ST_IDLE      | nothing in flight; SPI request takes priority over a frame request
// ST_SPI       | SPI bytes forwarded straight to the PHY until spi_valid drops
// ST_WAIT_SYNC | frame accepted, waiting for the tearing-effect strobe
// ST_CMD       | emitting the 11-byte window/RAMWR preamble
// ST_PIX       | streaming RGB565 pixels, high byte first
module lcd_frame_sched
    import lcd_pkg::*;
#(
    parameter int H_RES = 320,
    parameter int V_RES = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fmark_stb,
    input  logic        frame_req,
    output logic        frame_busy,
    output logic        frame_done,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [7:0]  spi_data,
    input  logic        spi_rs,
    input  logic        spi_valid,
    output logic        spi_ready,
    output logic [7:0]  phy_data,
    output logic        phy_rs,
    output logic        phy_valid,
    input  logic        phy_ready
);

    localparam logic [31:0] PIX_TOTAL = 32'(H_RES) * 32'(V_RES);

    sched_state_t state, state_nxt;
    logic [3:0]   cmd_idx, cmd_idx_nxt;
    logic         pix_sel, pix_sel_nxt;
    logic [31:0]  pix_cnt, pix_cnt_nxt;
    logic         cmd_rs;
    logic [7:0]   cmd_data;

`ifndef LCD_SCHED_TEARSYNC_EN
    logic unused_fmark;
    assign unused_fmark = fmark_stb;
`endif

    lcd_sched_cmdseq #(
        .H_RES(H_RES),
        .V_RES(V_RES)
    ) u_cmdseq (
        .idx  (cmd_idx),
        .rs   (cmd_rs),
        .data (cmd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cmd_idx <= 4'd0;
            pix_sel <= 1'b0;
            pix_cnt <= 32'd0;
        end else begin
            state   <= state_nxt;
            cmd_idx <= cmd_idx_nxt;
            pix_sel <= pix_sel_nxt;
            pix_cnt <= pix_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cmd_idx_nxt = cmd_idx;
        pix_sel_nxt = pix_sel;
        pix_cnt_nxt = pix_cnt;
        phy_valid   = 1'b0;
        phy_data    = 8'h00;
        phy_rs      = 1'b0;
        pix_ready   = 1'b0;
        spi_ready   = 1'b0;
        frame_busy  = 1'b0;
        frame_done  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (spi_valid)
                    state_nxt = ST_SPI;
                else if (frame_req)
                    state_nxt = ST_WAIT_SYNC;
            end
            ST_SPI: begin
                phy_valid = spi_valid;
                phy_data  = spi_data;
                phy_rs    = spi_rs;
                spi_ready = phy_ready;
                if (!spi_valid)
                    state_nxt = ST_IDLE;
            end
            ST_WAIT_SYNC: begin
                frame_busy = 1'b1;
`ifdef LCD_SCHED_TEARSYNC_EN
                if (fmark_stb)
                    state_nxt = ST_CMD;
`else
                state_nxt = ST_CMD;
`endif
            end
            ST_CMD: begin
                frame_busy = 1'b1;
                phy_valid  = 1'b1;
                phy_data   = cmd_data;
                phy_rs     = cmd_rs;
                if (phy_ready) begin
                    if (cmd_idx == CMD_LAST) begin
                        cmd_idx_nxt = 4'd0;
                        state_nxt   = ST_PIX;
                    end else begin
                        cmd_idx_nxt = cmd_idx + 4'd1;
                    end
                end
            end
            ST_PIX: begin
                frame_busy = 1'b1;
                phy_valid  = pix_valid;
                phy_rs     = 1'b1;
                phy_data   = pix_sel ? pix_data[7:0] : pix_data[15:8];
                if (pix_valid && phy_ready) begin
                    if (!pix_sel) begin
                        pix_sel_nxt = 1'b1;
                    end else begin
                        // pixel is consumed from the source only once both bytes are out
                        pix_sel_nxt = 1'b0;
                        pix_ready   = 1'b1;
                        if (pix_cnt == PIX_TOTAL - 32'd1) begin
                            pix_cnt_nxt = 32'd0;
                            frame_done  = 1'b1;
                            state_nxt   = ST_IDLE;
                        end else begin
                            pix_cnt_nxt = pix_cnt + 32'd1;
                        end
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (!rst_n) begin
            phy_valid  = 1'b0;
            phy_data   = 8'h00;
            phy_rs     = 1'b0;
            pix_ready  = 1'b0;
            spi_ready  = 1'b0;
            frame_busy = 1'b0;
            frame_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_lcd_frame_sched.sv
// Directed/randomised bench for lcd_frame_sched (H_RES=4, V_RES=2) with a byte-stream reference model.
module tb_lcd_frame_sched;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int NPIX = H * V;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fmark_stb = 1'b0;
    logic        frame_req = 1'b0;
    logic        frame_busy, frame_done;
    logic [15:0] pix_data = 16'h0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [7:0]  spi_data = 8'h0;
    logic        spi_rs = 1'b0;
    logic        spi_valid = 1'b0;
    logic        spi_ready;
    logic [7:0]  phy_data;
    logic        phy_rs, phy_valid;
    logic        phy_ready = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int pix_acc  = 0;
    int busy_spi_viol = 0;
    int idle_pix_viol = 0;

    logic [8:0]  cap_q[$];
    logic [8:0]  exp_q[$];
    logic [8:0]  spi_q[$];
    logic [15:0] pix_q[$];

    always #5 clk = ~clk;

    lcd_frame_sched #(.H_RES(H), .V_RES(V)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fmark_stb  (fmark_stb),
        .frame_req  (frame_req),
        .frame_busy (frame_busy),
        .frame_done (frame_done),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .spi_data   (spi_data),
        .spi_rs     (spi_rs),
        .spi_valid  (spi_valid),
        .spi_ready  (spi_ready),
        .phy_data   (phy_data),
        .phy_rs     (phy_rs),
        .phy_valid  (phy_valid),
        .phy_ready  (phy_ready)
    );

    // inputs change just after posedge, so values at negedge are what the next edge commits
    always @(negedge clk) begin
        if (phy_valid && phy_ready) cap_q.push_back({phy_rs, phy_data});
        if (frame_done) done_cnt++;
        if (pix_ready) pix_acc++;
        if (frame_busy && spi_ready) busy_spi_viol++;
        if (!frame_busy && pix_ready) idle_pix_viol++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " phy_valid"}, 32'(phy_valid), 32'd0);
        chk({tag, " phy_data"}, 32'(phy_data), 32'd0);
        chk({tag, " phy_rs"}, 32'(phy_rs), 32'd0);
        chk({tag, " pix_ready"}, 32'(pix_ready), 32'd0);
        chk({tag, " spi_ready"}, 32'(spi_ready), 32'd0);
        chk({tag, " frame_busy"}, 32'(frame_busy), 32'd0);
        chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
    endtask

    // Expected PHY bytes for one frame: window preamble then the first n_exp pixels.
    task automatic load_frame(input int n_exp, input bit fixed);
        logic [15:0] p, hl, vl;
        hl = 16'(H - 1);
        vl = 16'(V - 1);
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back(9'h100);
        exp_q.push_back(9'h100);
        exp_q.push_back({1'b1, hl[15:8]});
        exp_q.push_back({1'b1, hl[7:0]});
        exp_q.push_back({1'b0, 8'h2B});
        exp_q.push_back(9'h100);
        exp_q.push_back(9'h100);
        exp_q.push_back({1'b1, vl[15:8]});
        exp_q.push_back({1'b1, vl[7:0]});
        exp_q.push_back({1'b0, 8'h2C});
        for (int i = 0; i < NPIX; i++) begin
            p = 16'($urandom);
            if (fixed && i == 0) p = 16'h1234;
            if (fixed && i == 1) p = 16'hABCD;
            pix_q.push_back(p);
            if (i < n_exp) begin
                exp_q.push_back({1'b1, p[15:8]});
                exp_q.push_back({1'b1, p[7:0]});
            end
        end
    endtask

    task automatic check_stream(input string tag);
        chk({tag, " length"}, 32'(cap_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            chk(tag, 32'(cap_q[i]), 32'(exp_q[i]));
        cap_q.delete();
        exp_q.delete();
    endtask

    // rmode: 0 = phy_ready high, 1 = toggling, 2 = random
    task automatic run(input int max_cyc, input int done_tgt, input int pix_tgt,
                       input int rmode, input bit gaps, input bit spi_wait);
        bit spi_hs, pix_hs, hit;
        hit = 1'b0;
        for (int c = 0; c < max_cyc && !hit; c++) begin
            @(negedge clk);
            spi_hs = spi_valid && spi_ready;
            pix_hs = pix_valid && pix_ready;
            if (frame_busy) frame_req = 1'b0;
            @(posedge clk);
            #1;
            if (spi_hs) void'(spi_q.pop_front());
            if (pix_hs) void'(pix_q.pop_front());
            spi_valid = (spi_q.size() != 0);
            if (spi_q.size() != 0) {spi_rs, spi_data} = spi_q[0];
            pix_valid = (pix_q.size() != 0) && (!gaps || $urandom_range(0, 3) != 0);
            if (pix_q.size() != 0) pix_data = pix_q[0];
            case (rmode)
                0:       phy_ready = 1'b1;
                1:       phy_ready = ~phy_ready;
                default: phy_ready = 1'($urandom_range(0, 1));
            endcase
            fmark_stb = (c % 7 == 3);
            hit = ((done_cnt >= done_tgt) || (pix_acc >= pix_tgt)) && (!spi_wait || spi_q.size() == 0);
        end
        fmark_stb = 1'b0;
        chk("run within cycle budget", 32'(hit), 32'd1);
    endtask

    initial begin
        bit seen;

        // reset with every input active: outputs must still be forced low
        rst_n = 1'b0; spi_valid = 1'b1; frame_req = 1'b1; pix_valid = 1'b1;
        phy_ready = 1'b1; spi_data = 8'h55; pix_data = 16'hFFFF; fmark_stb = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk); #1;
        spi_valid = 1'b0; frame_req = 1'b0; pix_valid = 1'b0; fmark_stb = 1'b0; rst_n = 1'b1;
        cap_q.delete(); done_cnt = 0; pix_acc = 0;
        @(negedge clk);
        chk("idle after reset busy", 32'(frame_busy), 32'd0);

        // basic frame, PHY always ready
        load_frame(NPIX, 1'b0);
        frame_req = 1'b1;
        phy_ready = 1'b1;
        run(400, 1, 1000, 0, 1'b0, 1'b0);
        check_stream("frame1");
        chk("frame1 done pulses", 32'(done_cnt), 32'd1);
        chk("frame1 pix_ready pulses", 32'(pix_acc), 32'(NPIX));
        @(negedge clk);
        chk("frame1 busy after done", 32'(frame_busy), 32'd0);

        // SPI and frame requested together: SPI bytes first
        done_cnt = 0; pix_acc = 0;
        for (int i = 0; i < 3; i++) begin
            spi_q.push_back(9'($urandom));
            exp_q.push_back(spi_q[i]);
        end
        load_frame(NPIX, 1'b0);
        @(posedge clk); #1;
        spi_valid = 1'b1;
        {spi_rs, spi_data} = spi_q[0];
        frame_req = 1'b1;
        run(600, 1, 1000, 2, 1'b1, 1'b0);
        check_stream("spi_first");
        chk("spi_first done pulses", 32'(done_cnt), 32'd1);

        // fixed pixels with toggling ready; SPI arrives mid-frame and must wait
        done_cnt = 0; pix_acc = 0;
        load_frame(NPIX, 1'b1);
        frame_req = 1'b1;
        run(400, 99, 1, 1, 1'b0, 1'b0);
        spi_q.push_back({1'b0, 8'h9C});
        spi_valid = 1'b1;
        {spi_rs, spi_data} = spi_q[0];
        phy_ready = 1'b0;
        @(negedge clk);
        chk("spi held during frame ready", 32'(spi_ready), 32'd0);
        chk("spi held during frame busy", 32'(frame_busy), 32'd1);
        exp_q.push_back({1'b0, 8'h9C});
        run(600, 1, 1000, 1, 1'b0, 1'b1);
        check_stream("toggle");
        chk("toggle pix_ready pulses", 32'(pix_acc), 32'(NPIX));
        chk("toggle done pulses", 32'(done_cnt), 32'd1);

        // reset after 5 pixels aborts the frame
        done_cnt = 0; pix_acc = 0;
        load_frame(5, 1'b0);
        frame_req = 1'b1;
        phy_ready = 1'b1;
        run(400, 1, 5, 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        pix_valid = 1'b1;
        @(negedge clk);
        chk_outputs_zero("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        pix_valid = 1'b0;
        pix_q.delete();
        check_stream("abort");
        chk("abort no frame_done", 32'(done_cnt), 32'd0);
        load_frame(NPIX, 1'b0);
        frame_req = 1'b1;
        run(600, 1, 1000, 2, 1'b1, 1'b0);
        check_stream("after_abort");
        chk("after_abort done pulses", 32'(done_cnt), 32'd1);

`ifndef LCD_SCHED_TEARSYNC_EN
        // no tearing sync: first opcode within 3 cycles with fmark_stb low
        done_cnt = 0; pix_acc = 0;
        load_frame(NPIX, 1'b0);
        @(posedge clk); #1;
        phy_ready = 1'b0;
        fmark_stb = 1'b0;
        frame_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (phy_valid && !phy_rs && phy_data == 8'h2A) seen = 1'b1;
        end
        chk("no tearsync 2A within 3", 32'(seen), 32'd1);
        run(600, 1, 1000, 2, 1'b1, 1'b0);
        check_stream("no_tearsync");
`endif

        chk("spi_ready while busy", 32'(busy_spi_viol), 32'd0);
        chk("pix_ready while not busy", 32'(idle_pix_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
